// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles from accepted start to done.
// Signed mode multiplies magnitudes and negates the final sum; en_mult is ignored while busy.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_mult,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_sum;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_start;
  logic                 w_last;

  // Negating the most-negative value wraps back to itself, which read unsigned is the correct magnitude.
  assign w_mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_result = r_neg ? -w_sum : w_sum;
  assign w_start  = en_mult && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = en_mult ? S_RUN : S_IDLE;
      S_RUN:   w_next = (r_cnt == LAST) ? S_DONE : S_RUN;
      S_DONE:  w_next = en_mult ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiplicand shifts left and multiplier right each step, so bit 0 is always the current bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      product_hi <= '0;
      product_lo <= '0;
    end else if (w_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        {product_hi, product_lo} <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=32); inputs change and outputs are sampled on the falling edge.
module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en_mult = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .en_mult    (en_mult),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .product_hi (product_hi),
    .product_lo (product_lo),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Caller is at a falling edge; returns at the falling edge just after the accepting rising edge.
  task automatic start(input logic [31:0] op_a, input logic [31:0] op_b, input logic sgn);
    en_mult   = 1'b1;
    a         = op_a;
    b         = op_b;
    is_signed = sgn;
    @(negedge clock);
    en_mult = 1'b0;
  endtask

  // Counts falling edges until done (bounded) and how many of the samples before done showed busy.
  task automatic wait_done(output int cycles, output int nbusy);
    cycles = 0;
    nbusy  = 0;
    while (!done && cycles < 100) begin
      if (busy) nbusy++;
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks += 4;
    if (product_hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h want=%h", product_lo, 32'h0); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_unsigned_basic;
    int cyc, nb;
    start(32'd3, 32'd5, 1'b0);
    wait_done(cyc, nb);
    checks += 4;
    if (cyc !== 32) begin failures++; $display("FAIL basic_latency got=%0d want=32", cyc); end
    if (nb !== 32) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=32", nb); end
    if (product_hi !== 32'h0) begin failures++; $display("FAIL basic_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'hF) begin failures++; $display("FAIL basic_lo got=%h want=%h", product_lo, 32'hF); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_signed;
    int cyc, nb;
    start(32'hFFFF_FFFF, 32'h0000_0007, 1'b1);
    wait_done(cyc, nb);
    checks += 2;
    if (product_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL neg1x7_hi got=%h want=%h", product_hi, 32'hFFFF_FFFF); end
    if (product_lo !== 32'hFFFF_FFF9) begin failures++; $display("FAIL neg1x7_lo got=%h want=%h", product_lo, 32'hFFFF_FFF9); end
    @(negedge clock);
    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc, nb);
    checks += 2;
    if (product_hi !== 32'h0) begin failures++; $display("FAIL minxneg1_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'h8000_0000) begin failures++; $display("FAIL minxneg1_lo got=%h want=%h", product_lo, 32'h8000_0000); end
    @(negedge clock);
    start(32'h0, 32'hFFFF_FFFB, 1'b1);
    wait_done(cyc, nb);
    checks += 2;
    if (product_hi !== 32'h0) begin failures++; $display("FAIL zero_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'h0) begin failures++; $display("FAIL zero_lo got=%h want=%h", product_lo, 32'h0); end
    @(negedge clock);
  endtask

  task automatic test_max;
    int cyc, nb;
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc, nb);
    checks += 2;
    if (product_hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL umax_hi got=%h want=%h", product_hi, 32'hFFFF_FFFE); end
    if (product_lo !== 32'h0000_0001) begin failures++; $display("FAIL umax_lo got=%h want=%h", product_lo, 32'h1); end
    @(negedge clock);
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc, nb);
    checks += 2;
    if (product_hi !== 32'h0) begin failures++; $display("FAIL smax_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'h1) begin failures++; $display("FAIL smax_lo got=%h want=%h", product_lo, 32'h1); end
    @(negedge clock);
  endtask

  task automatic test_ignore_busy;
    int cyc, nb, ndone;
    start(32'd6, 32'd7, 1'b0);
    repeat (9) @(negedge clock);
    start(32'd9, 32'd9, 1'b0);
    wait_done(cyc, nb);
    checks += 3;
    if (done !== 1'b1) begin failures++; $display("FAIL ignore_done got=%b want=1", done); end
    if (product_hi !== 32'h0) begin failures++; $display("FAIL ignore_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'd42) begin failures++; $display("FAIL ignore_lo got=%0d want=42", product_lo); end
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
    end
    checks += 2;
    if (ndone !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d want=0", ndone); end
    if (busy !== 1'b0 || product_lo !== 32'd42) begin
      failures++; $display("FAIL ignore_idle got busy=%b lo=%0d want busy=0 lo=42", busy, product_lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, nb;
    start(32'd2, 32'd3, 1'b0);
    wait_done(cyc, nb);
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b want=1", done); end
    if (product_lo !== 32'd6 || product_hi !== 32'h0) begin
      failures++; $display("FAIL b2b_first got=%h_%h want=%h_%h", product_hi, product_lo, 32'h0, 32'd6);
    end
    start(32'h0001_0000, 32'h0001_0000, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_restart got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(cyc, nb);
    checks += 3;
    if (cyc !== 32) begin failures++; $display("FAIL b2b_latency got=%0d want=32", cyc); end
    if (product_hi !== 32'h1) begin failures++; $display("FAIL b2b_hi got=%h want=%h", product_hi, 32'h1); end
    if (product_lo !== 32'h0) begin failures++; $display("FAIL b2b_lo got=%h want=%h", product_lo, 32'h0); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    int cyc, nb;
    start(32'h1234, 32'h5678, 1'b0);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks += 2;
    if (product_hi !== 32'h0 || product_lo !== 32'h0) begin
      failures++; $display("FAIL abort_outputs got=%h_%h want=0_0", product_hi, product_lo);
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done);
    end
    start(32'h1234, 32'h5678, 1'b0);
    wait_done(cyc, nb);
    checks += 3;
    if (cyc !== 32) begin failures++; $display("FAIL restart_latency got=%0d want=32", cyc); end
    if (product_hi !== 32'h0) begin failures++; $display("FAIL restart_hi got=%h want=%h", product_hi, 32'h0); end
    if (product_lo !== 32'h0626_0060) begin failures++; $display("FAIL restart_lo got=%h want=%h", product_lo, 32'h0626_0060); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_max();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; the product width is 2*WIDTH and the run length is WIDTH cycles.
REQ-002 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en_mult, input, 1 bit: start request from the ALU multiply decode.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 = MULT (two's complement), 0 = MULTU; sampled with en_mult.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands; sampled with en_mult.
REQ-007 The block SHALL have port product_hi, output, WIDTH bits: upper half of the last completed product; registered.
REQ-008 The block SHALL have port product_lo, output, WIDTH bits: lower half of the last completed product; registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse when product_hi and product_lo take a new result.

Function
REQ-011 The FSM SHALL have three states:
- IDLE: waiting for a start request.
- RUN: iterating.
- DONE: one-cycle completion state.
REQ-012 A start SHALL be accepted on a rising edge where en_mult=1 and the state is IDLE or DONE. At that edge the block SHALL:
- latch |a| and |b|: the magnitudes if is_signed=1, the raw values if is_signed=0;
- latch neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
- clear the 2*WIDTH accumulator;
- set the iteration counter to 0;
- enter RUN.
REQ-013 On each edge in RUN, the block SHALL perform one shift-add step: if multiplier bit[counter]=1, add the multiplicand shifted left by counter to the accumulator; then increment counter.
REQ-014 On the WIDTH-th RUN edge, the block SHALL:
- write {product_hi, product_lo} = neg ? -(final accumulator) : final accumulator, computed modulo 2^(2*WIDTH);
- enter DONE.
REQ-015 busy SHALL be 1 exactly in RUN, i.e. for WIDTH cycles after the accepting edge; done SHALL be 1 exactly in DONE; latency from the accepting edge to done=1 SHALL be WIDTH cycles.
REQ-016 From DONE, the FSM SHALL go to RUN if en_mult=1 (back-to-back start), otherwise to IDLE.
REQ-017 en_mult asserted during RUN SHALL be ignored: the operands, the in-flight result and the outputs SHALL be unaffected, and no queueing SHALL occur.
REQ-018 product_hi and product_lo SHALL hold the last result unchanged in IDLE, RUN and DONE until the next REQ-014 write; a new start SHALL NOT clear them.
REQ-019 Magnitude of the most-negative operand (-2^(WIDTH-1)) SHALL be taken as unsigned 2^(WIDTH-1), which is correct in WIDTH bits, with no overflow flag.
REQ-020 A zero operand SHALL yield product 0 regardless of the neg flag.
REQ-021 With WIDTH=32, the result SHALL equal the MIPS MULT/MULTU definition: HI = bits 63:32, LO = bits 31:0.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL:
- enter IDLE;
- set product_hi=0, product_lo=0, busy=0 and done=0;
- clear the accumulator and counter.
This SHALL take priority over en_mult and over any in-flight operation.
REQ-023 A reset asserted mid-RUN SHALL abort the operation, with no partial result written to product_hi or product_lo and no done pulse.
REQ-024 In the first cycle after reset deasserts, the block SHALL accept en_mult=1.

Verification
REQ-025 Unsigned basic: is_signed=0, a=3, b=5, en_mult pulsed at edge E0 -> busy=1 for cycles E0..E31, done=1 only after E32, hi=0x00000000, lo=0x0000000F.
REQ-026 Signed mixed and extreme: a=0xFFFFFFFF (-1), b=0x00000007, signed -> hi=0xFFFFFFFF, lo=0xFFFFFFF9; a=0x80000000, b=0xFFFFFFFF, signed -> hi=0x00000000, lo=0x80000000.
REQ-027 Unsigned maximum: a=b=0xFFFFFFFF, unsigned -> hi=0xFFFFFFFE, lo=0x00000001; the same operands signed -> hi=0, lo=1.
REQ-028 Start ignored while busy: start 6*7 unsigned, then pulse en_mult with a=9, b=9 ten cycles later -> result hi=0, lo=42, exactly one done pulse, FSM back in IDLE.
REQ-029 Back-to-back: hold en_mult=1 in the DONE cycle of 2*3 with the new operands 0x10000*0x10000 -> lo=6 with done, then after a further 32 cycles hi=0x00000001, lo=0 with a second done; busy low only during the DONE cycle.
REQ-030 Reset mid-operation: start 0x1234*0x5678, assert reset at RUN cycle 15 for one edge -> outputs 0, no done pulse; a fresh start on the next cycle completes normally with lo=0x06260060.
